mult_div_sequencer: RTL and testbench

MULT_DIV_SEQUENCER -- requirements
Module: mult_div_sequencer

---
 rtl/mult_div_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// Multi-cycle HI/LO multiply/divide sequencer: IDLE -> CALC (DATA_W steps) -> FIX (2 cycles).
// The FIX state first sign-corrects the result, then commits it to hi/lo and pulses done.
// Optional feature macro: MD_DIV_EN adds the restoring-divide datapath and DIV/DIVU support.
module mult_div_sequencer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              hilo_rd,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              stall,
    output logic              done
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned LAST  = DATA_W - 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                fix_ph;
    logic [DATA_W-1:0]   m_reg;
    logic [DATA_W-1:0]   acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic                neg_lo;

    logic                sgn;
    logic                rs_neg;
    logic                rt_neg;
    logic [DATA_W-1:0]   rs_mag;
    logic [DATA_W-1:0]   rt_mag;
    logic                accept;
    logic [DATA_W:0]     madd;
    logic [DATA_W-1:0]   step_hi;
    logic [DATA_W-1:0]   step_lo;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;

`ifdef MD_DIV_EN
    logic                op_div;
    logic                neg_hi;
    logic                div0;
    logic [DATA_W:0]     dsh;
    logic [DATA_W:0]     ddiff;
    logic                dge;
`endif

    assign busy  = (state != IDLE);
    assign stall = busy & (start | hilo_rd);

    // operand magnitudes and op acceptance
    always_comb begin
        sgn    = ~md_op[0];
        rs_neg = sgn & rs_val[DATA_W-1];
        rt_neg = sgn & rt_val[DATA_W-1];
        rs_mag = rs_neg ? -rs_val : rs_val;
        rt_mag = rt_neg ? -rt_val : rt_val;
`ifdef MD_DIV_EN
        accept = start & ~flush & (state == IDLE);
`else
        accept = start & ~flush & (state == IDLE) & ~md_op[1];
`endif
    end

    // one iteration step: shift-add multiply, or restoring shift-subtract divide
    always_comb begin
        madd    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_reg} : (DATA_W+1)'(0));
        step_hi = madd[DATA_W:1];
        step_lo = {madd[0], acc_lo[DATA_W-1:1]};
`ifdef MD_DIV_EN
        dsh   = {acc_hi, acc_lo[DATA_W-1]};
        ddiff = dsh - {1'b0, m_reg};
        dge   = (dsh >= {1'b0, m_reg});
        if (op_div) begin
            step_hi = dge ? ddiff[DATA_W-1:0] : dsh[DATA_W-1:0];
            step_lo = {acc_lo[DATA_W-2:0], dge};
        end
`endif
    end

    // two's-complement sign correction applied in the first FIX cycle
    always_comb begin
        prod_fix = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        fix_hi   = prod_fix[2*DATA_W-1:DATA_W];
        fix_lo   = prod_fix[DATA_W-1:0];
`ifdef MD_DIV_EN
        if (op_div) begin
            fix_lo = div0 ? {DATA_W{1'b1}} : (neg_lo ? -acc_lo : acc_lo);
            fix_hi = neg_hi ? -acc_hi : acc_hi;
        end
`endif
    end

    // state machine, datapath registers and architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            fix_ph <= 1'b0;
            m_reg  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg_lo <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
`ifdef MD_DIV_EN
            op_div <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (flush) begin
                state  <= IDLE;
                cnt    <= '0;
                fix_ph <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                        if (accept) begin
                            state  <= CALC;
                            cnt    <= '0;
                            acc_hi <= '0;
                            neg_lo <= rs_neg ^ rt_neg;
`ifdef MD_DIV_EN
                            op_div <= md_op[1];
                            neg_hi <= md_op[1] & rs_neg;
                            div0   <= md_op[1] & (rt_val == '0);
                            if (md_op[1]) begin
                                m_reg  <= rt_mag;
                                acc_lo <= rs_mag;
                            end else begin
                                m_reg  <= rs_mag;
                                acc_lo <= rt_mag;
                            end
`else
                            m_reg  <= rs_mag;
                            acc_lo <= rt_mag;
`endif
                        end
                    end
                    CALC: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(LAST)) begin
                            state <= FIX;
                            cnt   <= '0;
                        end
                    end
                    FIX: begin
                        if (!fix_ph) begin
                            acc_hi <= fix_hi;
                            acc_lo <= fix_lo;
                            fix_ph <= 1'b1;
                        end else begin
                            hi     <= acc_hi;
                            lo     <= acc_lo;
                            done   <= 1'b1;
                            fix_ph <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: stimulus pushes expected HI/LO and completion cycle,
// an independent monitor pops and compares on every done pulse.
module tb_mult_div_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        hilo_rd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned cyc;
    int          n_cmp;
    int          n_err;
    bit          chk_pulse;

    mult_div_sequencer #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .flush   (flush),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .hilo_rd (hilo_rd),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall   (stall),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one op for a single edge; optionally record the expected completion
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        step();
        start  = 1'b0;
        if (expect_done) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.cyc = cyc + 34;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("idle_timeout", 64'(busy), 64'(0));
        step();
        check("sb_drained", 64'(sb_q.size()), 64'(0));
    endtask

    // monitor: compare every done pulse against the scoreboard head
    initial begin
        chk_pulse = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (chk_pulse) begin
                check("done_one_cycle", 64'(done), 64'(0));
                chk_pulse = 1'b0;
            end else if (rst_n === 1'b1 && done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    check("hi", 64'(hi), 64'(mon_e.hi));
                    check("lo", 64'(lo), 64'(mon_e.lo));
                    check("latency", 64'(cyc), 64'(mon_e.cyc));
                    chk_pulse = 1'b1;
                end
            end
        end
    end

    initial begin
        int n;
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        md_op   = 2'b00;
        rs_val  = '0;
        rt_val  = '0;
        flush   = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        hilo_rd = 1'b0;
        repeat (3) step();

        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        rst_n = 1'b1;
        step();

        // multiply vectors
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
        wait_idle();
        issue(2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
        wait_idle();
        issue(2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 1'b1, 32'h00000000, 32'h0000001E);
        wait_idle();
        issue(2'b01, 32'h80000000, 32'h00000002, 1'b1, 32'h00000001, 32'h00000000);
        wait_idle();
        issue(2'b00, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
        wait_idle();

`ifdef MD_DIV_EN
        // divide vectors incl. divide-by-zero and most-negative / -1
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_idle();
        issue(2'b11, 32'h00000064, 32'h00000000, 1'b1, 32'h00000064, 32'hFFFFFFFF);
        wait_idle();
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000);
        wait_idle();
        issue(2'b10, 32'h00000007, 32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD);
        wait_idle();
        issue(2'b11, 32'hFFFFFFFF, 32'h00000010, 1'b1, 32'h0000000F, 32'h0FFFFFFF);
        wait_idle();
        issue(2'b10, 32'hFFFFFFFB, 32'h00000000, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF);
        wait_idle();
`else
        // divide not built: DIVU start must be ignored
        start  = 1'b1;
        md_op  = 2'b11;
        rs_val = 32'h64;
        rt_val = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("nodiv_busy", 64'(busy), 64'(0));
            check("nodiv_stall", 64'(stall), 64'(0));
            check("nodiv_done", 64'(done), 64'(0));
        end
        start = 1'b0;
        check("nodiv_hi", 64'(hi), 64'(32'h40000000));
        check("nodiv_lo", 64'(lo), 64'(32'h00000000));
`endif

        // stall on MFHI/MFLO and ignored start while busy
        issue(2'b01, 32'h3, 32'h5, 1'b1, 32'h0, 32'hF);
        repeat (4) step();
        hilo_rd = 1'b1;
        start   = 1'b1;
        md_op   = 2'b00;
        rs_val  = 32'h7;
        rt_val  = 32'h7;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stall_start", 64'(stall), 64'(1));
            step();
        end
        start = 1'b0;
        n = 0;
        while (n < 60) begin
            #1;
            if (busy !== 1'b1) break;
            check("stall_hilo", 64'(stall), 64'(1));
            step();
            n++;
        end
        check("stall_release", 64'(stall), 64'(0));
        hilo_rd = 1'b0;
        step();
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        // flush mid-CALC keeps HI/LO and suppresses done
        hi_we = 1'b1;
        wdata = 32'h1234;
        step();
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h5678;
        step();
        lo_we = 1'b0;
        check("mthi", 64'(hi), 64'(32'h1234));
        check("mtlo", 64'(lo), 64'(32'h5678));
        issue(2'b01, 32'h3, 32'h5, 1'b0, 32'h0, 32'h0);
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle", 64'(busy), 64'(0));
        repeat (40) step();
        check("flush_hi", 64'(hi), 64'(32'h1234));
        check("flush_lo", 64'(lo), 64'(32'h5678));

        // flush in IDLE blocks acceptance of start
        flush = 1'b1;
        start = 1'b1;
        md_op = 2'b01;
        step();
        check("flush_start_busy", 64'(busy), 64'(0));
        flush = 1'b0;
        start = 1'b0;
        step();
        check("flush_start_busy2", 64'(busy), 64'(0));

        // asynchronous reset mid-op
        issue(2'b00, 32'hFFFFFFFD, 32'h7, 1'b0, 32'h0, 32'h0);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'(0));
        check("arst_lo", 64'(lo), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        step();
        rst_n = 1'b1;
        repeat (40) step();
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_hi", 64'(hi), 64'(0));

        // MTHI together with start takes effect now; writes while busy are ignored
        hi_we = 1'b1;
        wdata = 32'hAAAA5555;
        issue(2'b01, 32'h3, 32'h5, 1'b1, 32'h0, 32'hF);
        hi_we = 1'b0;
        check("mthi_with_start", 64'(hi), 64'(32'hAAAA5555));
        lo_we = 1'b1;
        wdata = 32'hDEADBEEF;
        step();
        lo_we = 1'b0;
        check("mtlo_busy_ignored", 64'(lo), 64'(0));
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
